// File: rtl/xadc_drp_sequencer_if.sv
// DRP bus between the sequencer (master) and the XADC primitive (slave).
// One outstanding transaction at a time; DEN/DWE are single-cycle pulses.
interface xadc_drp_sequencer_if;
  logic [6:0]  DADDR;
  logic        DEN;
  logic        DWE;
  logic [15:0] DI;
  logic [15:0] DO;
  logic        DRDY;

  modport master (
    output DADDR, DEN, DWE, DI,
    input  DO, DRDY
  );

  modport slave (
    input  DADDR, DEN, DWE, DI,
    output DO, DRDY
  );
endinterface

// File: rtl/xadc_drp_sequencer.sv
// Reads each converted XADC channel over DRP into a sample stream and
// slots host config writes onto the same DRP, yielding to JTAG.
module xadc_drp_sequencer #(
  parameter int unsigned TIMEOUT_CYC = 64
) (
  input  logic        DCLK,
  input  logic        RESETN,
  input  logic        EOC,
  input  logic [4:0]  CHANNEL,
  input  logic        JTAGLOCKED,
  xadc_drp_sequencer_if.master drp,
  input  logic        CFG_WE,
  input  logic [6:0]  CFG_ADDR,
  input  logic [15:0] CFG_DATA,
  output logic        CFG_BUSY,
  output logic [11:0] SAMPLE_DATA,
  output logic [4:0]  SAMPLE_CH,
  output logic        SAMPLE_VALID,
  input  logic        SAMPLE_READY,
  output logic        OVERRUN,
  output logic        TIMEOUT_ERR,
  input  logic        CLR_ERR
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RD_WAIT = 2'd1,
    WR_WAIT = 2'd2
  } state_e;

  localparam logic [15:0] TO_LAST = 16'(TIMEOUT_CYC - 1);

  state_e      state_q, state_d;
  logic        den_q, den_d;
  logic        dwe_q, dwe_d;
  logic [6:0]  daddr_q, daddr_d;
  logic [15:0] di_q, di_d;
  logic [15:0] cnt_q, cnt_d;
  logic        rd_pend_q, rd_pend_d;
  logic [4:0]  ch_q, ch_d;
  logic        busy_q, busy_d;
  logic [6:0]  cfg_addr_q, cfg_addr_d;
  logic [15:0] cfg_data_q, cfg_data_d;
  logic        sv_q, sv_d;
  logic [11:0] sd_q, sd_d;
  logic [4:0]  sc_q, sc_d;
  logic        ovr_q, ovr_d;
  logic        to_q, to_d;
  logic        rd_issue;
  logic        rd_done;
  logic        ovr_set;
  logic        to_set;
  logic        unused_do;

  assign unused_do = ^drp.DO[3:0];

  always_comb begin
    state_d    = state_q;
    den_d      = 1'b0;
    dwe_d      = 1'b0;
    daddr_d    = daddr_q;
    di_d       = di_q;
    cnt_d      = cnt_q;
    rd_pend_d  = rd_pend_q;
    ch_d       = ch_q;
    busy_d     = busy_q;
    cfg_addr_d = cfg_addr_q;
    cfg_data_d = cfg_data_q;
    sv_d       = sv_q;
    sd_d       = sd_q;
    sc_d       = sc_q;
    rd_issue   = 1'b0;
    rd_done    = 1'b0;
    ovr_set    = 1'b0;
    to_set     = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (!JTAGLOCKED) begin
          if (rd_pend_q) begin
            rd_issue  = 1'b1;
            den_d     = 1'b1;
            daddr_d   = {2'b00, ch_q};
            rd_pend_d = 1'b0;
            cnt_d     = '0;
            state_d   = RD_WAIT;
          end else if (busy_q) begin
            den_d   = 1'b1;
            dwe_d   = 1'b1;
            daddr_d = cfg_addr_q;
            di_d    = cfg_data_q;
            cnt_d   = '0;
            state_d = WR_WAIT;
          end
        end
      end
      RD_WAIT: begin
        if (drp.DRDY) begin
          rd_done = 1'b1;
          state_d = IDLE;
        end else if (cnt_q == TO_LAST) begin
          to_set  = 1'b1;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      WR_WAIT: begin
        if (drp.DRDY) begin
          busy_d  = 1'b0;
          state_d = IDLE;
        end else if (cnt_q == TO_LAST) begin
          to_set  = 1'b1;
          busy_d  = 1'b0;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      default: state_d = IDLE;
    endcase

    // A fresh EOC re-arms the read even on the edge the old one issues
    if (EOC) begin
      if (rd_pend_q && !rd_issue) ovr_set = 1'b1;
      rd_pend_d = 1'b1;
      ch_d      = CHANNEL;
    end

    if (CFG_WE && !busy_q) begin
      busy_d     = 1'b1;
      cfg_addr_d = CFG_ADDR;
      cfg_data_d = CFG_DATA;
    end

    if (sv_q && SAMPLE_READY) sv_d = 1'b0;
    if (rd_done) begin
      if (sv_q && !SAMPLE_READY) begin
        ovr_set = 1'b1;
      end else begin
        sv_d = 1'b1;
        sd_d = drp.DO[15:4];
        sc_d = daddr_q[4:0];
      end
    end

    ovr_d = ovr_set | (ovr_q & ~CLR_ERR);
    to_d  = to_set | (to_q & ~CLR_ERR);
  end

  always_ff @(posedge DCLK or negedge RESETN) begin
    if (!RESETN) begin
      state_q    <= IDLE;
      den_q      <= 1'b0;
      dwe_q      <= 1'b0;
      daddr_q    <= '0;
      di_q       <= '0;
      cnt_q      <= '0;
      rd_pend_q  <= 1'b0;
      ch_q       <= '0;
      busy_q     <= 1'b0;
      cfg_addr_q <= '0;
      cfg_data_q <= '0;
      sv_q       <= 1'b0;
      sd_q       <= '0;
      sc_q       <= '0;
      ovr_q      <= 1'b0;
      to_q       <= 1'b0;
    end else begin
      state_q    <= state_d;
      den_q      <= den_d;
      dwe_q      <= dwe_d;
      daddr_q    <= daddr_d;
      di_q       <= di_d;
      cnt_q      <= cnt_d;
      rd_pend_q  <= rd_pend_d;
      ch_q       <= ch_d;
      busy_q     <= busy_d;
      cfg_addr_q <= cfg_addr_d;
      cfg_data_q <= cfg_data_d;
      sv_q       <= sv_d;
      sd_q       <= sd_d;
      sc_q       <= sc_d;
      ovr_q      <= ovr_d;
      to_q       <= to_d;
    end
  end

  assign drp.DADDR    = daddr_q;
  assign drp.DEN      = den_q;
  assign drp.DWE      = dwe_q;
  assign drp.DI       = di_q;
  assign CFG_BUSY     = busy_q;
  assign SAMPLE_DATA  = sd_q;
  assign SAMPLE_CH    = sc_q;
  assign SAMPLE_VALID = sv_q;
  assign OVERRUN      = ovr_q;
  assign TIMEOUT_ERR  = to_q;

endmodule

// File: tb/tb_xadc_drp_sequencer.sv
// Bench for xadc_drp_sequencer: DRP responder model plus a sample
// scoreboard fed at EOC time and drained on stream handshakes.
module tb_xadc_drp_sequencer;

  logic        DCLK;
  logic        RESETN;
  logic        EOC;
  logic [4:0]  CHANNEL;
  logic        JTAGLOCKED;
  logic        CFG_WE;
  logic [6:0]  CFG_ADDR;
  logic [15:0] CFG_DATA;
  logic        CFG_BUSY;
  logic [11:0] SAMPLE_DATA;
  logic [4:0]  SAMPLE_CH;
  logic        SAMPLE_VALID;
  logic        SAMPLE_READY;
  logic        OVERRUN;
  logic        TIMEOUT_ERR;
  logic        CLR_ERR;

  xadc_drp_sequencer_if drp_if ();

  xadc_drp_sequencer #(.TIMEOUT_CYC(8)) dut (
    .DCLK         (DCLK),
    .RESETN       (RESETN),
    .EOC          (EOC),
    .CHANNEL      (CHANNEL),
    .JTAGLOCKED   (JTAGLOCKED),
    .drp          (drp_if.master),
    .CFG_WE       (CFG_WE),
    .CFG_ADDR     (CFG_ADDR),
    .CFG_DATA     (CFG_DATA),
    .CFG_BUSY     (CFG_BUSY),
    .SAMPLE_DATA  (SAMPLE_DATA),
    .SAMPLE_CH    (SAMPLE_CH),
    .SAMPLE_VALID (SAMPLE_VALID),
    .SAMPLE_READY (SAMPLE_READY),
    .OVERRUN      (OVERRUN),
    .TIMEOUT_ERR  (TIMEOUT_ERR),
    .CLR_ERR      (CLR_ERR)
  );

  int n_vec = 0;
  int n_err = 0;

  logic [16:0] sb[$];

  // responder state
  int          den_cnt = 0;
  int          rcnt = 0;
  int          lat = 3;
  bit          mute = 1'b0;
  bit          den_prev = 1'b0;
  bit          den_double = 1'b0;
  int          stray_n = 0;
  int          stray_done = 0;
  logic [15:0] rsp = '0;
  logic [6:0]  la[64];
  logic        lw[64];
  logic [15:0] ld[64];

  initial begin
    DCLK = 1'b0;
    forever #5 DCLK = ~DCLK;
  end

  initial begin
    drp_if.DRDY = 1'b0;
    drp_if.DO   = '0;
    forever begin
      @(negedge DCLK);
      drp_if.DRDY = 1'b0;
      if (rcnt != 0) begin
        rcnt--;
        if (rcnt == 0) begin
          drp_if.DRDY = 1'b1;
          drp_if.DO   = rsp;
        end
      end
      if (stray_n != stray_done) begin
        stray_done  = stray_n;
        drp_if.DRDY = 1'b1;
        drp_if.DO   = rsp;
      end
      if (drp_if.DEN) begin
        if (den_prev) den_double = 1'b1;
        la[den_cnt % 64] = drp_if.DADDR;
        lw[den_cnt % 64] = drp_if.DWE;
        ld[den_cnt % 64] = drp_if.DI;
        den_cnt++;
        if (!mute) rcnt = lat;
      end
      den_prev = drp_if.DEN;
    end
  end

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge DCLK);
    #1;
  endtask

  task automatic eoc(input logic [4:0] ch);
    EOC = 1'b1;
    CHANNEL = ch;
    tick();
    EOC = 1'b0;
  endtask

  task automatic take_sample(input string tag);
    int k;
    logic [16:0] e;
    k = 0;
    while (!SAMPLE_VALID && k < 40) begin
      tick();
      k++;
    end
    chk({tag, "_valid"}, 32'(SAMPLE_VALID), 32'd1);
    if (SAMPLE_VALID) begin
      if (sb.size() == 0) begin
        chk({tag, "_sb"}, 32'(sb.size()), 32'd1);
      end else begin
        e = sb.pop_front();
        chk({tag, "_ch"}, 32'(SAMPLE_CH), 32'(e[16:12]));
        chk({tag, "_data"}, 32'(SAMPLE_DATA), 32'(e[11:0]));
      end
      SAMPLE_READY = 1'b1;
      tick();
      SAMPLE_READY = 1'b0;
      chk({tag, "_drop"}, 32'(SAMPLE_VALID), 32'd0);
    end
  endtask

  function automatic logic [31:0] outs();
    return 32'({drp_if.DEN, drp_if.DWE, drp_if.DADDR, CFG_BUSY,
                SAMPLE_VALID, SAMPLE_CH, OVERRUN, TIMEOUT_ERR})
         | 32'({drp_if.DI, SAMPLE_DATA} != 28'd0);
  endfunction

  initial begin
    int k;
    int n0;
    RESETN = 1'b0;
    EOC = 1'b0;
    CHANNEL = '0;
    JTAGLOCKED = 1'b0;
    CFG_WE = 1'b0;
    CFG_ADDR = '0;
    CFG_DATA = '0;
    SAMPLE_READY = 1'b0;
    CLR_ERR = 1'b0;
    repeat (3) tick();
    chk("rst_outs", outs(), 32'd0);
    RESETN = 1'b1;
    tick();

    // basic read
    rsp = 16'hABC0;
    sb.push_back({5'h10, 12'hABC});
    eoc(5'h10);
    chk("rd_den_early", 32'(drp_if.DEN), 32'd0);
    tick();
    chk("rd_den", 32'(drp_if.DEN), 32'd1);
    chk("rd_addr", 32'(drp_if.DADDR), 32'h10);
    chk("rd_dwe", 32'(drp_if.DWE), 32'd0);
    tick();
    chk("rd_den_pulse", 32'(drp_if.DEN), 32'd0);
    k = 0;
    while (!SAMPLE_VALID && k < 20) begin
      tick();
      k++;
    end
    repeat (3) tick();
    chk("rd_hold", 32'({SAMPLE_VALID, SAMPLE_CH, SAMPLE_DATA}),
        32'({1'b1, 5'h10, 12'hABC}));
    take_sample("rd");

    // config write colliding with a read
    n0 = den_cnt;
    rsp = 16'h1230;
    sb.push_back({5'h00, 12'h123});
    CFG_WE = 1'b1;
    CFG_ADDR = 7'h41;
    CFG_DATA = 16'h2000;
    eoc(5'h00);
    CFG_WE = 1'b0;
    chk("cw_busy", 32'(CFG_BUSY), 32'd1);
    CFG_WE = 1'b1;
    CFG_ADDR = 7'h42;
    CFG_DATA = 16'h1111;
    tick();
    CFG_WE = 1'b0;
    k = 0;
    while (den_cnt < n0 + 2 && k < 50) begin
      tick();
      k++;
    end
    chk("cw_dens", 32'(den_cnt - n0), 32'd2);
    chk("cw_first", 32'({lw[n0 % 64], la[n0 % 64]}), 32'h00);
    chk("cw_second", 32'({lw[(n0 + 1) % 64], la[(n0 + 1) % 64]}),
        32'({1'b1, 7'h41}));
    chk("cw_di", 32'(ld[(n0 + 1) % 64]), 32'h2000);
    k = 0;
    while (CFG_BUSY && k < 20) begin
      tick();
      k++;
    end
    chk("cw_busy_drop", 32'(CFG_BUSY), 32'd0);
    take_sample("cw");
    repeat (5) tick();
    chk("cw_no_extra", 32'(den_cnt - n0), 32'd2);

    // back-pressure
    rsp = 16'h5550;
    sb.push_back({5'h03, 12'h555});
    eoc(5'h03);
    k = 0;
    while (!SAMPLE_VALID && k < 20) begin
      tick();
      k++;
    end
    chk("bp_ovr_pre", 32'(OVERRUN), 32'd0);
    rsp = 16'h7770;
    eoc(5'h04);
    repeat (10) tick();
    chk("bp_ovr", 32'(OVERRUN), 32'd1);
    take_sample("bp");
    CLR_ERR = 1'b1;
    tick();
    CLR_ERR = 1'b0;
    chk("bp_clr", 32'({OVERRUN, TIMEOUT_ERR}), 32'd0);

    // timeout
    mute = 1'b1;
    eoc(5'h07);
    k = 0;
    while (!drp_if.DEN && k < 10) begin
      tick();
      k++;
    end
    chk("to_den", 32'(drp_if.DEN), 32'd1);
    repeat (7) tick();
    chk("to_early", 32'(TIMEOUT_ERR), 32'd0);
    tick();
    chk("to_set", 32'(TIMEOUT_ERR), 32'd1);
    mute = 1'b0;
    rsp = 16'h0420;
    sb.push_back({5'h02, 12'h042});
    eoc(5'h02);
    take_sample("to_next");
    chk("to_sticky", 32'(TIMEOUT_ERR), 32'd1);
    CLR_ERR = 1'b1;
    tick();
    CLR_ERR = 1'b0;
    chk("to_clr", 32'(TIMEOUT_ERR), 32'd0);

    // JTAG lock
    JTAGLOCKED = 1'b1;
    rsp = 16'h9990;
    sb.push_back({5'h09, 12'h999});
    eoc(5'h09);
    n0 = den_cnt;
    repeat (5) tick();
    chk("jt_hold", 32'(den_cnt - n0), 32'd0);
    JTAGLOCKED = 1'b0;
    tick();
    chk("jt_den", 32'({drp_if.DEN, drp_if.DADDR}), 32'({1'b1, 7'h09}));
    take_sample("jt");

    // reset mid-read, then a stray DRDY
    mute = 1'b1;
    eoc(5'h01);
    tick();
    tick();
    chk("rr_busy", 32'(drp_if.DADDR), 32'h01);
    RESETN = 1'b0;
    #1;
    chk("rr_outs", outs(), 32'd0);
    tick();
    RESETN = 1'b1;
    mute = 1'b0;
    tick();
    n0 = den_cnt;
    rsp = 16'hFFF0;
    stray_n++;
    repeat (6) tick();
    chk("rr_stray", 32'({SAMPLE_VALID, TIMEOUT_ERR}), 32'd0);
    chk("rr_no_den", 32'(den_cnt - n0), 32'd0);

    chk("den_single", 32'(den_double), 32'd0);
    chk("sb_empty", 32'(sb.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/xadc_drp_sequencer.md
Name: xadc_drp_sequencer

Overview:
- Sits directly downstream of the XADC primitive wrapper and drives its DRP port.
- On each End-of-Conversion (EOC) from the XADC, reads that channel's result register over the DRP and presents a 12-bit sample with its channel tag on a valid/ready stream.
- Also arbitrates single host configuration writes onto the same DRP.
- Yields the DRP entirely while JTAG holds the lock.

Parameters:
- TIMEOUT_CYC, 64, DCLK cycles allowed between DEN and DRDY before a transaction is abandoned (range 2..65535).

Ports:
- DCLK  in  1  DRP clock; all logic on the rising edge.
- RESETN  in  1  asynchronous active-low reset.
- EOC  in  1  end-of-conversion pulse from the XADC.
- CHANNEL  in  5  channel of the completed conversion, valid with EOC.
- JTAGLOCKED  in  1  JTAG owns the DRP; start no new transaction while high.
- DADDR  out  7  DRP address.
- DEN  out  1  DRP enable, single-cycle pulse.
- DWE  out  1  DRP write enable, only with DEN.
- DI  out  16  DRP write data.
- DO  in  16  DRP read data.
- DRDY  in  1  DRP transaction complete.
- CFG_WE  in  1  host configuration write request pulse.
- CFG_ADDR  in  7  configuration register address.
- CFG_DATA  in  16  configuration write data.
- CFG_BUSY  out  1  a configuration write is pending or in flight.
- SAMPLE_DATA  out  12  conversion result, DO[15:4].
- SAMPLE_CH  out  5  channel of SAMPLE_DATA.
- SAMPLE_VALID  out  1  sample available.
- SAMPLE_READY  in  1  consumer accepts the sample.
- OVERRUN  out  1  sticky: an EOC or a sample was lost.
- TIMEOUT_ERR  out  1  sticky: DRDY was not seen within TIMEOUT_CYC.
- CLR_ERR  in  1  synchronous clear of OVERRUN and TIMEOUT_ERR.

Behaviour:
- Reset (RESETN low, asynchronous): all outputs 0 (DADDR, DI, SAMPLE_* = 0; DEN, DWE, CFG_BUSY, SAMPLE_VALID, OVERRUN, TIMEOUT_ERR = 0); FSM in IDLE; pending flags and counter cleared. Reset mid-transaction abandons it; a DRDY arriving after reset release while in IDLE is ignored.
- EOC capture: EOC high at edge t sets rd_pend and latches CHANNEL.
  - EOC while rd_pend is already set: overwrite the channel, set OVERRUN.
  - EOC during RD_WAIT/WR_WAIT: pends normally.
- CFG capture: CFG_WE with CFG_BUSY low latches CFG_ADDR/CFG_DATA; CFG_BUSY goes high next cycle. CFG_WE while CFG_BUSY is high is ignored.
- FSM states: IDLE, RD_WAIT, WR_WAIT.
- IDLE, JTAGLOCKED low, rd_pend set:
  - DEN=1, DWE=0, DADDR={2'b00,ch} for one cycle; clear rd_pend; go to RD_WAIT.
  - Minimum latency: EOC at edge t gives DEN high in the cycle after t+1.
- IDLE, JTAGLOCKED low, rd_pend clear, cfg pending:
  - DEN=1, DWE=1, DADDR=cfg addr, DI=cfg data for one cycle; go to WR_WAIT.
  - A read pending in the same cycle wins; the write waits.
- IDLE, JTAGLOCKED high: nothing issued; pending requests are held.
- Timeout counter: cleared when DEN is issued; increments each wait cycle.
- RD_WAIT, DRDY high: capture DO[15:4] and the channel into the output register, subject to stream rules; return to IDLE.
- WR_WAIT, DRDY high: CFG_BUSY low next cycle; return to IDLE.
- Wait-state timeout: counter reaching TIMEOUT_CYC-1 without DRDY sets TIMEOUT_ERR and returns to IDLE.
  - Read timeout: no sample produced.
  - Write timeout: CFG_BUSY is dropped.
- Stream rules:
  - SAMPLE_VALID rises the cycle after the read DRDY.
  - SAMPLE_VALID holds, with data stable, until SAMPLE_READY is seen high.
  - New result while SAMPLE_VALID && !SAMPLE_READY: new result dropped, old sample kept, OVERRUN set.
  - New result while SAMPLE_VALID && SAMPLE_READY: new result replaces the old one; VALID stays high.
- CLR_ERR: clears both sticky flags. If CLR_ERR coincides with a new error event, the set wins.
- DEN is never asserted while in RD_WAIT or WR_WAIT (at most one outstanding DRP transaction).

Test Plan:
- Basic read: EOC with CHANNEL=5'h10, DO=16'hABC0 returned 3 cycles after DEN -> DEN/DADDR=7'h10 one cycle, DWE=0; SAMPLE_VALID with SAMPLE_DATA=12'hABC, SAMPLE_CH=5'h10; held until SAMPLE_READY.
- Config write vs read collision: CFG_WE (addr 7'h41, data 16'h2000) and EOC (ch 0) in the same cycle -> read issued first; write issued after read DRDY with DWE=1, DI=16'h2000; CFG_BUSY drops after write DRDY.
- Back-pressure: SAMPLE_READY held low over two conversions -> first sample retained, second dropped, OVERRUN=1; CLR_ERR -> OVERRUN=0.
- Timeout: DRDY never returned with TIMEOUT_CYC=8 -> TIMEOUT_ERR=1 eight cycles after DEN, FSM idle; a following EOC is serviced normally.
- JTAG lock: JTAGLOCKED high, EOC arrives -> no DEN; on lock release, DEN is issued within 1 cycle with the latched channel.
- Reset mid-read: RESETN low during RD_WAIT -> all outputs 0 immediately; a stray DRDY after release produces no sample.
